// File: rtl/pwm_gate_capture.sv
// Receive-side monitor for a dead-time gate pair. It measures the high, dead, low and period times in clk cycles.
// Optional macro PWM_CAPTURE_SYNC_EN adds a 2-flop input synchronizer, which adds 2 cycles of latency.
module pwm_gate_capture #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate_high,
  input  logic             gate_low,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] t_high,
  output logic [CNT_W-1:0] t_dt_hl,
  output logic [CNT_W-1:0] t_low,
  output logic [CNT_W-1:0] t_dt_lh,
  output logic [CNT_W-1:0] t_period,
  output logic             meas_valid,
  output logic             meas_ovf,
  output logic             shoot_flt,
  output logic             timeout
);

  typedef enum logic [2:0] {IDLE, HIGH, DT1, LOW, DT2} state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam int unsigned      IW   = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0]    TO_V = IW'(TIMEOUT);

  logic h_in, l_in;
  logic h_s_q, l_s_q, h_d_q, l_d_q;

`ifdef PWM_CAPTURE_SYNC_EN
  logic [1:0] h_sync_q, l_sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sync_q <= '0;
      l_sync_q <= '0;
    end else begin
      h_sync_q <= {h_sync_q[0], gate_high};
      l_sync_q <= {l_sync_q[0], gate_low};
    end
  end
  assign h_in = h_sync_q[1];
  assign l_in = l_sync_q[1];
`else
  assign h_in = gate_high;
  assign l_in = gate_low;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] c_high_q, c_dt1_q, c_low_q, c_dt2_q, c_per_q;
  logic [CNT_W-1:0] c_high_d, c_dt1_d, c_low_d, c_dt2_d, c_per_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [CNT_W-1:0] t_high_q, t_dt_hl_q, t_low_q, t_dt_lh_q, t_period_q;
  logic             meas_valid_q, meas_ovf_q, shoot_q, timeout_q;
  logic             rise_h, any_edge, publish, sat, timeout_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + CNT_W'(1);
  endfunction

  assign rise_h   = h_s_q & ~h_d_q;
  assign any_edge = (h_s_q ^ h_d_q) | (l_s_q ^ l_d_q);
  assign sat      = (c_high_q == CMAX) | (c_dt1_q == CMAX) | (c_low_q == CMAX) |
                    (c_dt2_q == CMAX) | (c_per_q == CMAX);

  always_comb begin
    state_d   = state_q;
    c_high_d  = c_high_q;
    c_dt1_d   = c_dt1_q;
    c_low_d   = c_low_q;
    c_dt2_d   = c_dt2_q;
    c_per_d   = c_per_q;
    idle_d    = idle_q;
    publish   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      HIGH:    if (!h_s_q) state_d = l_s_q ? LOW : DT1;
      DT1:     if (l_s_q) state_d = LOW;
      LOW:     if (!l_s_q) state_d = DT2;
      default: ;
    endcase

    // The rise sample is the first cycle of the new period, so the high and period counters restart at 1.
    if (rise_h) begin
      state_d  = HIGH;
      publish  = (state_q != IDLE);
      c_high_d = CNT_W'(1);
      c_per_d  = CNT_W'(1);
      c_dt1_d  = '0;
      c_low_d  = '0;
      c_dt2_d  = '0;
    end else if (state_q != IDLE) begin
      c_per_d = sat_inc(c_per_q);
      case (state_d)
        HIGH:    c_high_d = sat_inc(c_high_q);
        DT1:     c_dt1_d  = sat_inc(c_dt1_q);
        LOW:     c_low_d  = sat_inc(c_low_q);
        DT2:     c_dt2_d  = sat_inc(c_dt2_q);
        default: ;
      endcase
    end

    if (state_q == IDLE && !rise_h) begin
      idle_d = '0;
    end else if (any_edge) begin
      idle_d = IW'(1);
    end else begin
      idle_d = idle_q + IW'(1);
      if (idle_d == TO_V) begin
        timeout_d = 1'b1;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_s_q        <= 1'b0;
      l_s_q        <= 1'b0;
      h_d_q        <= 1'b0;
      l_d_q        <= 1'b0;
      state_q      <= IDLE;
      c_high_q     <= '0;
      c_dt1_q      <= '0;
      c_low_q      <= '0;
      c_dt2_q      <= '0;
      c_per_q      <= '0;
      idle_q       <= '0;
      t_high_q     <= '0;
      t_dt_hl_q    <= '0;
      t_low_q      <= '0;
      t_dt_lh_q    <= '0;
      t_period_q   <= '0;
      meas_valid_q <= 1'b0;
      meas_ovf_q   <= 1'b0;
      shoot_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      h_s_q        <= h_in;
      l_s_q        <= l_in;
      h_d_q        <= h_s_q;
      l_d_q        <= l_s_q;
      state_q      <= state_d;
      c_high_q     <= c_high_d;
      c_dt1_q      <= c_dt1_d;
      c_low_q      <= c_low_d;
      c_dt2_q      <= c_dt2_d;
      c_per_q      <= c_per_d;
      idle_q       <= idle_d;
      meas_valid_q <= publish;
      meas_ovf_q   <= publish & sat;
      timeout_q    <= timeout_d;
      if (publish) begin
        t_high_q   <= c_high_q;
        t_dt_hl_q  <= c_dt1_q;
        t_low_q    <= c_low_q;
        t_dt_lh_q  <= c_dt2_q;
        t_period_q <= c_per_q;
      end
      // A new overlap wins over a simultaneous clear.
      if (h_s_q & l_s_q)  shoot_q <= 1'b1;
      else if (fault_clr) shoot_q <= 1'b0;
    end
  end

  assign t_high     = t_high_q;
  assign t_dt_hl    = t_dt_hl_q;
  assign t_low      = t_low_q;
  assign t_dt_lh    = t_dt_lh_q;
  assign t_period   = t_period_q;
  assign meas_valid = meas_valid_q;
  assign meas_ovf   = meas_ovf_q;
  assign shoot_flt  = shoot_q;
  assign timeout    = timeout_q;

endmodule
